// File: rtl/bf_program_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bf_program_sequencer
// Description : Loads a brainfuck program from a byte stream into code RAM,
//               appends a 0x00 terminator, runs the core against the code
//               RAM and flags completion when the core parks on 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_program_sequencer #(
  parameter int addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                run_start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic [addrSize-1:0] ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                ram_we,
  input  logic [7:0]          ram_rdata,
  input  logic [addrSize-1:0] core_addr_code,
  output logic [7:0]          core_data_code,
  output logic                core_reset,
  output logic                loading,
  output logic                halted,
  output logic [addrSize-1:0] prog_len
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_TERM    = 3'd2,
    S_RESTART = 3'd3,
    S_RUN     = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  // Last program slot: one address is always kept free for the terminator.
  localparam logic [addrSize-1:0] C_WP_LAST = {{(addrSize-1){1'b1}}, 1'b0};

  state_t              state_q;
  logic [addrSize-1:0] wp_q;
  logic [1:0]          zc_q;
  logic [addrSize-1:0] prog_len_q;

  logic w_accept;
  logic w_core_side;

  assign w_accept    = (state_q == S_LOAD) && rx_valid;
  assign w_core_side = (state_q == S_RUN) || (state_q == S_HALTED);

  // Sequencer state, write pointer, zero counter and stored program length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      zc_q       <= '0;
      prog_len_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            wp_q    <= '0;
          end else if (run_start) begin
            state_q <= S_RESTART;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (rx_data == 8'h00) begin
              state_q <= S_TERM;
            end else begin
              wp_q <= wp_q + addrSize'(1);
              if (wp_q == C_WP_LAST) state_q <= S_TERM;
            end
          end
        end
        S_TERM: begin
          prog_len_q <= wp_q;
          state_q    <= S_RESTART;
        end
        S_RESTART: begin
          zc_q    <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (load_start) begin
            state_q <= S_LOAD;
            wp_q    <= '0;
          end else if (ram_rdata == 8'h00) begin
            // Three consecutive zero fetches mean the core is parked on the
            // terminator; a real instruction never reads 0x00 that long.
            zc_q <= zc_q + 2'd1;
            if (zc_q == 2'd2) state_q <= S_HALTED;
          end else begin
            zc_q <= '0;
          end
        end
        S_HALTED: begin
          if (load_start) begin
            state_q <= S_LOAD;
            wp_q    <= '0;
          end else if (run_start) begin
            state_q <= S_RESTART;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from the current state, registers and RAM/core inputs.
  always_comb begin
    rx_ready       = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = 8'h00;
    core_data_code = 8'h00;
    core_reset     = 1'b0;
    loading        = 1'b0;
    halted         = 1'b0;
    prog_len       = prog_len_q;
    case (state_q)
      S_LOAD: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        ram_addr = wp_q;
        if (w_accept && (rx_data != 8'h00)) begin
          ram_we    = 1'b1;
          ram_wdata = rx_data;
        end
      end
      S_TERM: begin
        loading  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = wp_q;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
    if (w_core_side) begin
      core_reset     = 1'b1;
      ram_addr       = core_addr_code;
      core_data_code = ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/bf_program_sequencer.md
# bf_program_sequencer

Owns the code RAM of the brainfuck processor and sequences `brainfuckCore`. It loads a program from a byte stream into code RAM and always appends a 0x00 terminator. It then releases the core from reset, muxes the code RAM to the core's code port, and flags completion when the core parks on the terminator. The block sits between the serial receiver, the code RAM (synchronous read, one-cycle latency) and the core.

## Interface
Parameters:
- `addrSize`, 9: code address width; capacity 2^addrSize bytes, including the terminator.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse; begin (re)loading a program.
- `run_start`  in  1  pulse; rerun the loaded program.
- `rx_valid`  in  1  stream byte valid.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  sequencer accepts a byte this cycle.
- `ram_addr`  out  addrSize  code RAM address.
- `ram_wdata`  out  8  code RAM write data.
- `ram_we`  out  1  code RAM write enable.
- `ram_rdata`  in  8  code RAM read data.
- `core_addr_code`  in  addrSize  core's code address.
- `core_data_code`  out  8  code byte presented to the core.
- `core_reset`  out  1  core's active-low reset.
- `loading`  out  1  high in LOAD and TERM.
- `halted`  out  1  high in HALTED.
- `prog_len`  out  addrSize  number of program bytes stored, excluding the terminator.

## Operation
- **States:** IDLE, LOAD, TERM, RESTART, RUN, HALTED. All outputs are decoded from the state and internal registers.
- **IDLE**
  - `core_reset`=0, `ram_addr`=0.
  - `load_start` → LOAD, with the write pointer `wp` cleared to 0.
  - `run_start` → RESTART.
- **LOAD**
  - `rx_ready`=1.
  - A byte is accepted when `rx_valid` && `rx_ready`.
  - Accepted nonzero byte: `ram_we`=1, `ram_addr`=`wp`, `ram_wdata`=`rx_data`, then `wp`++. If `wp` was 2^addrSize−2, go to TERM (capacity reached).
  - Accepted 0x00: no write; go to TERM.
- **TERM** (1 cycle)
  - Writes 0x00 at `wp`.
  - `prog_len` ← `wp`.
  - → RESTART.
- **RESTART** (1 cycle)
  - `core_reset`=0, clearing the zero counter `zc`.
  - → RUN.
- **RUN**
  - `core_reset`=1, `ram_addr`=`core_addr_code`, `core_data_code`=`ram_rdata`.
  - `zc` is a 2-bit counter. It increments while `core_data_code`==0 and clears on any nonzero byte. When it saturates at 3 → HALTED.
- **HALTED**
  - Same mux as RUN and `core_reset`=1, so the core stays parked.
  - `halted`=1.
  - `load_start` → LOAD; `run_start` → RESTART.
- **`load_start` in RUN** → LOAD. The core is held in reset from the next cycle.
- **`core_data_code`** is 0x00 in every state except RUN and HALTED.
- **Priority:** `load_start` beats `run_start` in the same cycle.
- **Ignored pulses:**
  - `load_start` and `run_start` are ignored in LOAD, TERM and RESTART.
  - `run_start` in RUN is ignored.
- **Writes** occur only in LOAD and TERM; the core can never write code RAM.
- **Address arithmetic** is addrSize bits; `wp` never wraps because TERM is forced at 2^addrSize−1.

## Timing
- **Reset values:**
  - state=IDLE, `wp`=0, `zc`=0, `prog_len`=0.
  - `rx_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `core_data_code`=0, `core_reset`=0, `loading`=0, `halted`=0.
- **Reset mid-operation:** asserting `reset` in any state returns to IDLE immediately (asynchronous). A partial program is not terminated.
- **Load throughput:** one byte per cycle while `rx_valid` is held.
- **0x00 terminator latency:** from the cycle the 0x00 is accepted, TERM follows next cycle, RESTART the one after, and `core_reset` rises on the third cycle.
- **Capacity-limit latency:** the cycle sequence (TERM, RESTART, `core_reset` rise) is the same as the 0x00 case.
- **Halt latency:** `halted` rises 3 cycles after the core first sees 0x00. The core waits at least 2 cycles per instruction, so this cannot false-trigger mid-program (no program byte is 0x00).
- **RAM read latency:** one cycle. `core_data_code` for the address issued at cycle n appears at n+1, which matches the core's wait cycles.

## Test plan
- **Basic load and run:** reset, `load_start`, stream "+." then 0x00 → RAM[0]=0x2B, RAM[1]=0x2E, RAM[2]=0x00; `prog_len`=2; `core_reset` rises 2 cycles after TERM; `halted` asserts after the core reaches address 2.
- **Capacity overflow:** addrSize=3, stream 10 bytes of 0x3E without a 0x00 → 7 bytes accepted; RAM[7]=0x00; `rx_ready` drops after the 7th byte; `prog_len`=7.
- **Rerun without reload:** `run_start` in HALTED → `core_reset` low for exactly 1 cycle, `halted` clears, the core refetches from address 0, and RAM contents are unchanged.
- **Reload during run:** `load_start` while RUN plus a simultaneous `run_start` → LOAD entered; `core_reset`=0 the next cycle; the new program overwrites from address 0.
- **Async reset mid-load:** assert `reset` mid-LOAD after 3 bytes → all outputs take their reset values within the same cycle; the next `load_start` restarts at `wp`=0.
- **Bytes outside LOAD:** `rx_valid` held high in IDLE/RUN → `rx_ready`=0 and `ram_we` never asserts.
